// File: rtl/sdtx_pkg.sv
`default_nettype none
//============================================================================
// Module      : sdtx_pkg
// Description : Shared types and constants for the SD DAT-line transmitter.
//               Holds the FSM state enum, the CRC16 polynomial and line levels.
// Revision    : 1.0 - initial release
//============================================================================
package sdtx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_CRC   = 3'd3,
    ST_STOP  = 3'd4
  } sdtx_state_t;

  localparam logic [15:0] C_CRC16_POLY  = 16'h1021;
  localparam logic [3:0]  C_LINE_IDLE   = 4'hF;
  localparam logic [3:0]  C_LINE_STOP   = 4'hF;
  localparam logic [3:0]  C_START_QUAD  = 4'h0;
  localparam logic [3:0]  C_START_1LANE = 4'hE;
  localparam int          C_MAX_LANES   = 4;

  // One serial step of x^16+x^12+x^5+1; feeding the current MSB back in
  // as the data bit simply shifts the register left by one.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din);
    logic [15:0] shifted;
    shifted = {crc[14:0], 1'b0};
    if (crc[15] ^ din) begin
      crc16_step = shifted ^ C_CRC16_POLY;
    end else begin
      crc16_step = shifted;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdtx_crc16.sv
`default_nettype none
//============================================================================
// Module      : sdtx_crc16
// Description : Bit-serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT lane,
//               with synchronous clear and step enable.
// Revision    : 1.0 - initial release
//============================================================================
module sdtx_crc16
  import sdtx_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_bit,
  output logic o_msb
);

  logic [15:0] r_crc;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_bit);
    end
  end

  assign o_msb = r_crc[15];

endmodule
`default_nettype wire

// File: rtl/sdtx_data.sv
`default_nettype none
//============================================================================
// Module      : sdtx_data
// Description : SD card DAT-line block transmitter (start, data, per-lane
//               CRC16, stop). Macro SDTX_QUAD_EN builds the 4-lane option.
// Revision    : 1.0 - initial release
//============================================================================
module sdtx_data
  import sdtx_pkg::*;
#(
  parameter int LGBLK = 9,
  parameter int BW    = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_quad,
  input  logic          i_ce,
  output logic          o_rd,
  input  logic [BW-1:0] i_data,
  input  logic          i_empty,
  output logic [3:0]    o_dat,
  output logic          o_dat_oe,
  output logic          o_busy,
  output logic          o_stall,
  output logic          o_done
);

  localparam logic [LGBLK:0] C_LAST_BYTE = {1'b0, {LGBLK{1'b1}}};

  sdtx_state_t    r_state;
  sdtx_state_t    w_state_nxt;

  logic           w_quad;
  logic [3:0]     r_dat;
  logic           r_oe;
  logic           r_done;
  logic [7:0]     r_shreg;
  logic [2:0]     r_sym_cnt;
  logic [LGBLK:0] r_byte_cnt;
  logic [3:0]     r_crc_cnt;

  logic           w_need;
  logic           w_adv;
  logic           w_last_sym;
  logic           w_last_byte;
  logic [7:0]     w_src;
  logic [3:0]     w_sym;
  logic [7:0]     w_shnext;
  logic [3:0]     w_lane_mask;
  logic [3:0]     w_lane_bit;
  logic [3:0]     w_lane_en;
  logic           w_crc_clr;
  logic [3:0]     w_crc_msb;
  logic [3:0]     w_crc_sym;

`ifdef SDTX_QUAD_EN
  localparam int NLANES = 4;

  // Lane mode is frozen at block acceptance so mid-block i_quad is harmless.
  logic r_quad;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_quad <= 1'b0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_quad <= i_quad;
    end
  end

  assign w_quad = r_quad;
`else
  localparam int NLANES = 1;

  logic w_unused_quad;
  assign w_unused_quad = i_quad;
  assign w_quad        = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start)                            w_state_nxt = ST_START;
      ST_START: if (i_ce)                               w_state_nxt = ST_DATA;
      ST_DATA:  if (w_adv && w_last_sym && w_last_byte) w_state_nxt = ST_CRC;
      ST_CRC:   if (i_ce && r_crc_cnt == 4'hF)          w_state_nxt = ST_STOP;
      ST_STOP:  if (i_ce && r_sym_cnt[0])               w_state_nxt = ST_IDLE;
      default:                                          w_state_nxt = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  //--------------------------------------------------------------------------
  always_comb begin
    w_need      = (r_state == ST_DATA) && (r_sym_cnt == 3'd0);
    o_stall     = w_need && i_empty;
    o_rd        = w_need && i_ce && !i_empty && !i_reset;
    w_adv       = i_ce && !o_stall;
    o_busy      = (r_state != ST_IDLE);
    w_last_sym  = w_quad ? (r_sym_cnt == 3'd1) : (r_sym_cnt == 3'd7);
    w_last_byte = (r_byte_cnt == C_LAST_BYTE);
    w_crc_clr   = (r_state == ST_IDLE);

    // First symbol comes straight from the FIFO head (fall-through).
    w_src = (r_sym_cnt == 3'd0) ? i_data : r_shreg;

    if (w_quad) begin
      w_sym       = w_src[7:4];
      w_shnext    = {w_src[3:0], 4'h0};
      w_lane_bit  = w_src[7:4];
      w_lane_mask = 4'hF;
      w_crc_sym   = w_crc_msb;
    end else begin
      w_sym       = {3'b111, w_src[7]};
      w_shnext    = {w_src[6:0], 1'b0};
      w_lane_bit  = {3'b000, w_src[7]};
      w_lane_mask = 4'h1;
      w_crc_sym   = {3'b111, w_crc_msb[0]};
    end

    w_lane_en = 4'h0;
    if (r_state == ST_DATA && w_adv) begin
      w_lane_en = w_lane_mask;
    end else if (r_state == ST_CRC && i_ce) begin
      w_lane_en  = w_lane_mask;
      w_lane_bit = w_crc_msb;
    end
  end

  //--------------------------------------------------------------------------
  // Line registers and counters
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dat      <= C_LINE_IDLE;
      r_oe       <= 1'b0;
      r_done     <= 1'b0;
      r_shreg    <= '0;
      r_sym_cnt  <= '0;
      r_byte_cnt <= '0;
      r_crc_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_dat      <= C_LINE_IDLE;
          r_oe       <= 1'b0;
          r_sym_cnt  <= '0;
          r_byte_cnt <= '0;
          r_crc_cnt  <= '0;
        end
        ST_START: begin
          if (i_ce) begin
            r_dat <= w_quad ? C_START_QUAD : C_START_1LANE;
            r_oe  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_adv) begin
            r_dat   <= w_sym;
            r_shreg <= w_shnext;
            if (w_last_sym) begin
              r_sym_cnt  <= '0;
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end else begin
              r_sym_cnt <= r_sym_cnt + 3'd1;
            end
          end
        end
        ST_CRC: begin
          if (i_ce) begin
            r_dat     <= w_crc_sym;
            r_crc_cnt <= r_crc_cnt + 4'd1;
          end
        end
        ST_STOP: begin
          // Symbol counter bit 0 tells the stop bit apart from the release cycle.
          if (i_ce) begin
            r_dat <= C_LINE_STOP;
            if (r_sym_cnt[0]) begin
              r_oe      <= 1'b0;
              r_done    <= 1'b1;
              r_sym_cnt <= '0;
            end else begin
              r_sym_cnt <= 3'd1;
            end
          end
        end
        default: begin
          r_dat <= C_LINE_IDLE;
          r_oe  <= 1'b0;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Per-lane CRC generators; absent lanes read back as idle-high
  //--------------------------------------------------------------------------
  for (genvar k = 0; k < C_MAX_LANES; k++) begin : g_lane
    if (k < NLANES) begin : g_crc
      sdtx_crc16 u_crc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_crc_clr),
        .i_en    (w_lane_en[k]),
        .i_bit   (w_lane_bit[k]),
        .o_msb   (w_crc_msb[k])
      );
    end else begin : g_absent
      logic w_unused_lane;
      assign w_unused_lane = w_lane_en[k] ^ w_lane_bit[k];
      assign w_crc_msb[k]  = 1'b1;
    end
  end

  assign o_dat    = r_dat;
  assign o_dat_oe = r_oe;
  assign o_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sdtx_data.sv
`default_nettype none
//============================================================================
// Module      : tb_sdtx_data
// Description : Self-checking bench for sdtx_data (LGBLK=9); honours SDTX_QUAD_EN.
// Revision    : 1.0 - initial release
//============================================================================
module tb_sdtx_data;

  localparam int LGBLK  = 9;
  localparam int NBYTES = 1 << LGBLK;
  localparam int BUDGET = 25000;
`ifdef SDTX_QUAD_EN
  localparam bit QUAD_EN = 1'b1;
`else
  localparam bit QUAD_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset, i_start, i_quad, i_ce, i_empty;
  logic [7:0] i_data;
  logic       o_rd, o_dat_oe, o_busy, o_stall, o_done;
  logic [3:0] o_dat;

  always #5 i_clk = ~i_clk;

  sdtx_data #(.LGBLK(LGBLK), .BW(8)) u_dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_quad   (i_quad),
    .i_ce     (i_ce),
    .o_rd     (o_rd),
    .i_data   (i_data),
    .i_empty  (i_empty),
    .o_dat    (o_dat),
    .o_dat_oe (o_dat_oe),
    .o_busy   (o_busy),
    .o_stall  (o_stall),
    .o_done   (o_done)
  );

  typedef struct {
    string name;
    bit    quad;       // value driven on i_quad at acceptance
    int    ce_div;     // i_ce every ce_div cycles
    int    pat;        // 0: all FF, 1: i*37+5, 2: 12,34,56,78 repeating
    int    gap;        // empty cycles after the first byte is read
    int    exp_stall;  // expected o_stall cycles
    bit    mid_start;  // pulse i_start while busy
    bit    golden_ff;  // check lane-0 CRC against 16'h7FA1
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mem [NBYTES];
  logic [3:0] exp_q [$];
  logic [3:0] got_q [$];
  vec_t       vecs [4];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    ref_crc = fb ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
  endfunction

  task automatic fill_mem(input int pat);
    logic [7:0] q [4];
    q[0] = 8'h12; q[1] = 8'h34; q[2] = 8'h56; q[3] = 8'h78;
    for (int i = 0; i < NBYTES; i++) begin
      case (pat)
        0:       mem[i] = 8'hFF;
        1:       mem[i] = 8'((i * 37) + 5);
        default: mem[i] = q[i % 4];
      endcase
    end
  endtask

  task automatic build_expected(input bit quad);
    logic [15:0] c [4];
    logic [7:0]  b;
    logic [3:0]  nib;
    for (int k = 0; k < 4; k++) c[k] = 16'h0;
    exp_q.delete();
    exp_q.push_back(quad ? 4'h0 : 4'hE);
    for (int i = 0; i < NBYTES; i++) begin
      b = mem[i];
      if (quad) begin
        for (int h = 1; h >= 0; h--) begin
          nib = (h == 1) ? b[7:4] : b[3:0];
          exp_q.push_back(nib);
          for (int k = 0; k < 4; k++) c[k] = ref_crc(c[k], nib[k]);
        end
      end else begin
        for (int j = 7; j >= 0; j--) begin
          exp_q.push_back({3'b111, b[j]});
          c[0] = ref_crc(c[0], b[j]);
        end
      end
    end
    for (int i = 15; i >= 0; i--) begin
      exp_q.push_back(quad ? {c[3][i], c[2][i], c[1][i], c[0][i]}
                           : {3'b111, c[0][i]});
    end
    exp_q.push_back(4'hF);
  endtask

  task automatic run_block(input vec_t v);
    bit         mode, prev_ce, prev_stall, prev_oe;
    logic [3:0] prev_dat;
    logic [15:0] crc_got;
    int rd_idx, rd_cnt, done_cnt, stall_cnt, gap_cnt, post, hold_err, bad_rd, n_mis;
    mode = QUAD_EN ? v.quad : 1'b0;
    fill_mem(v.pat);
    build_expected(mode);
    got_q.delete();
    rd_idx = 0; rd_cnt = 0; done_cnt = 0; stall_cnt = 0; gap_cnt = 0;
    post = 0; hold_err = 0; bad_rd = 0;
    prev_ce = 1'b0; prev_stall = 1'b0; prev_dat = o_dat; prev_oe = o_dat_oe;
    for (int cyc = 0; cyc < BUDGET && post < 8; cyc++) begin
      @(negedge i_clk);
      if (prev_ce && !prev_stall && o_dat_oe) got_q.push_back(o_dat);
      if (cyc > 0 && (!prev_ce || prev_stall) &&
          (o_dat !== prev_dat || o_dat_oe !== prev_oe)) hold_err++;
      if (o_done) done_cnt++;
      if (done_cnt > 0) post++;
      i_start = (cyc == 0) ||
                (v.mid_start && done_cnt == 0 && cyc > 20 && (cyc % 50) == 0);
      i_quad  = (cyc == 0) ? v.quad : ~i_quad;
      i_ce    = (cyc % v.ce_div) == 0;
      i_empty = (rd_idx >= NBYTES) || (gap_cnt > 0);
      i_data  = (rd_idx < NBYTES) ? mem[rd_idx] : 8'h00;
      #1;
      prev_stall = o_stall;
      if (o_stall) stall_cnt++;
      if (gap_cnt > 0) gap_cnt--;
      if (o_rd) begin
        if (i_empty) bad_rd++;
        rd_idx++;
        rd_cnt++;
        if (rd_idx == 1 && v.gap > 0) gap_cnt = v.gap;
      end
      prev_ce  = i_ce;
      prev_dat = o_dat;
      prev_oe  = o_dat_oe;
    end
    i_start = 1'b0;
    check({v.name, "_finished"}, 32'(done_cnt > 0), 32'd1);
    check({v.name, "_done_count"}, done_cnt, 1);
    check({v.name, "_rd_count"}, rd_cnt, NBYTES);
    check({v.name, "_rd_when_empty"}, bad_rd, 0);
    check({v.name, "_stall_cycles"}, stall_cnt, v.exp_stall);
    check({v.name, "_hold_between_ce"}, hold_err, 0);
    check({v.name, "_stream_len"}, got_q.size(), exp_q.size());
    n_mis = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) n_mis++;
    end
    check({v.name, "_stream_mismatches"}, n_mis, 0);
    if (got_q.size() > 0) check({v.name, "_start_symbol"}, got_q[0], mode ? 4'h0 : 4'hE);
    if (v.golden_ff && got_q.size() >= 1 + NBYTES * 8 + 16) begin
      for (int i = 0; i < 16; i++) crc_got[15 - i] = got_q[1 + NBYTES * 8 + i][0];
      check({v.name, "_crc_golden"}, crc_got, 16'h7FA1);
    end
    if (mode && got_q.size() > 8) begin
      for (int i = 0; i < 8; i++) check({v.name, "_first_nibbles"}, got_q[1 + i], 4'(i + 1));
    end
    check({v.name, "_idle_after"}, {o_busy, o_dat_oe, o_dat}, {1'b0, 1'b0, 4'hF});
  endtask

  task automatic reset_mid();
    int  rd_idx, dn;
    bit  hit;
    fill_mem(1);
    rd_idx = 0; hit = 1'b0; dn = 0;
    for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
      @(negedge i_clk);
      i_start = (cyc == 0);
      i_quad  = 1'b0;
      i_ce    = 1'b1;
      i_empty = 1'b0;
      i_data  = mem[rd_idx];
      #1;
      if (o_rd) begin
        if (rd_idx == 3) begin
          i_reset = 1'b1;
          #1;
          check("rst_mid_rd_in_reset", o_rd, 1'b0);
          hit = 1'b1;
        end else begin
          rd_idx++;
        end
      end
    end
    i_start = 1'b0;
    check("rst_mid_reached", hit, 1'b1);
    @(negedge i_clk);
    check("rst_mid_state", {o_busy, o_dat_oe, o_done, o_dat}, {1'b0, 1'b0, 1'b0, 4'hF});
    i_reset = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge i_clk);
      if (o_done || o_busy) dn++;
    end
    check("rst_mid_no_done", dn, 0);
  endtask

  initial begin
    vecs[0] = '{name: "ff_1lane",  quad: 1'b0, ce_div: 1, pat: 0, gap: 0,
                exp_stall: 0,  mid_start: 1'b0, golden_ff: 1'b1};
    vecs[1] = '{name: "stall_gap", quad: 1'b0, ce_div: 1, pat: 1, gap: 17,
                exp_stall: 10, mid_start: 1'b0, golden_ff: 1'b0};
    vecs[2] = '{name: "ce_div4",   quad: 1'b0, ce_div: 4, pat: 1, gap: 0,
                exp_stall: 0,  mid_start: 1'b0, golden_ff: 1'b0};
    vecs[3] = '{name: "quad_midst", quad: 1'b1, ce_div: 1, pat: 2, gap: 0,
                exp_stall: 0,  mid_start: 1'b1, golden_ff: 1'b0};

    i_reset = 1'b1; i_start = 1'b1; i_quad = 1'b0; i_ce = 1'b1;
    i_empty = 1'b0; i_data = 8'hA5;
    repeat (3) @(negedge i_clk);
    check("reset_busy",  o_busy,   1'b0);
    check("reset_dat",   o_dat,    4'hF);
    check("reset_oe",    o_dat_oe, 1'b0);
    check("reset_done",  o_done,   1'b0);
    check("reset_rd",    o_rd,     1'b0);
    check("reset_stall", o_stall,  1'b0);
    i_reset = 1'b0; i_start = 1'b0;
    @(negedge i_clk);
    check("idle_no_start", {o_busy, o_dat_oe}, 2'b00);

    for (int t = 0; t < 4; t++) run_block(vecs[t]);

    reset_mid();
    vecs[0].name      = "after_reset";
    vecs[0].pat       = 1;
    vecs[0].golden_ff = 1'b0;
    run_block(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
